// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the PC-source encodings, the controller FSM state type, the
// register-index type and small saturating-increment helpers.
package pipe_hazard_ctrl_pkg;

  // Architectural register index (x0..x31)
  typedef logic [4:0] reg_idx_t;

  // Next-PC selector encodings driven on pc_src
  localparam logic [2:0] PCSRC_SEQ  = 3'b000;  // PC + 4
  localparam logic [2:0] PCSRC_BR   = 3'b001;  // conditional branch target
  localparam logic [2:0] PCSRC_JAL  = 3'b010;  // JAL target
  localparam logic [2:0] PCSRC_JALR = 3'b011;  // JALR target

  // Controller states
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_JALR_WAIT = 2'd2
  } state_e;

  // 4-bit increment that sticks at 15
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // 16-bit increment that sticks at 16'hFFFF
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detector: flags when the instruction in ID reads a
// register that the load currently in EX has not yet produced.
// Writes to x0 never create a dependency.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic     ex_mem_read_i,
  input  reg_idx_t ex_rd_i,
  input  reg_idx_t id_rs1_i,
  input  reg_idx_t id_rs2_i,
  input  logic     id_use_rs1_i,
  input  logic     id_use_rs2_i,
  output logic     load_use_o
);

  // Compare the EX load destination against each source actually read in ID
  always_comb begin
    load_use_o = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                 ((id_use_rs1_i && (ex_rd_i == id_rs1_i)) ||
                  (id_use_rs2_i && (ex_rd_i == id_rs2_i)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order core.
// Mealy FSM (RUN / MEM_WAIT / JALR_WAIT) producing PC-source select,
// pipeline-register enables and flushes, with a MEM-stall timeout that
// force-releases the pipeline and pulses mem_fault.
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall_cnt and
// flush_cnt performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15  // legal range 2..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cond_hand_out,
  input  logic       jal,
  input  logic       jalr,
  input  reg_idx_t   id_rs1,
  input  reg_idx_t   id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  reg_idx_t   ex_rd,
  input  logic       ex_mem_read,
  input  logic       mem_req,
  input  logic       mem_ack,
  output logic [2:0] pc_src,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       if_id_reset,
  output logic       id_ex_reset,
  output logic       mem_fault
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);

  // Last counter value before the wait is forcibly abandoned
  localparam logic [3:0] TIMEOUT_LAST = 4'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       load_use;
  logic       mem_stall;
  logic       run_eval;      // apply the RUN priority rules this cycle
  logic       run_mem_term;  // whether the MEM-stall term participates

  hazard_detect u_hazard_detect (
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_i       (ex_rd),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_use_rs1_i  (id_use_rs1),
    .id_use_rs2_i  (id_use_rs2),
    .load_use_o    (load_use)
  );

  assign mem_stall = mem_req & ~mem_ack;

  // State and timeout counter registers; reset abandons any pending wait
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and Mealy outputs; reset forces a held, flushed pipeline
  always_comb begin
    pc_src       = PCSRC_SEQ;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_reset  = 1'b0;
    id_ex_reset  = 1'b0;
    mem_fault    = 1'b0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_eval     = 1'b0;
    run_mem_term = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        run_eval     = 1'b1;
        run_mem_term = mem_stall;
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          run_eval = 1'b1;
        end else if (cnt_q == TIMEOUT_LAST) begin
          // Give up on the access: report it and let the pipeline move
          mem_fault = 1'b1;
          run_eval  = 1'b1;
        end else begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          cnt_d     = sat_inc4(cnt_q);
        end
      end
      ST_JALR_WAIT: begin
        if (mem_stall) begin
          // Redirect stays pending until memory lets the pipeline go
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
        end else begin
          pc_src      = PCSRC_JALR;
          if_id_reset = 1'b1;
          state_d     = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (run_eval) begin
      if (run_mem_term) begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        state_d   = ST_MEM_WAIT;
        cnt_d     = 4'd0;
      end else if (cond_hand_out) begin
        pc_src      = PCSRC_BR;
        if_id_reset = 1'b1;
        id_ex_reset = 1'b1;
        state_d     = ST_RUN;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_reset = 1'b1;
        state_d     = ST_RUN;
      end else if (jal) begin
        pc_src      = PCSRC_JAL;
        if_id_reset = 1'b1;
        state_d     = ST_RUN;
      end else if (jalr) begin
        // One bubble while EX computes the JALR target
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_reset = 1'b1;
        state_d     = ST_JALR_WAIT;
      end else begin
        state_d = ST_RUN;
      end
    end

    if (!rst_n) begin
      pc_src      = PCSRC_SEQ;
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      if_id_reset = 1'b1;
      id_ex_reset = 1'b1;
      mem_fault   = 1'b0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating counts of stalled-PC cycles and IF/ID flush cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (!pc_en)      stall_cnt_q <= sat_inc16(stall_cnt_q);
      if (if_id_reset) flush_cnt_q <= sat_inc16(flush_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max MEM_WAIT cycles before forced release (range 2..15).
REQ-002 SHALL have ports: clk  in  1  pipeline clock.
REQ-003 rst_n  in  1  reset; one clock, reset asynchronous, active-low.
REQ-004 cond_hand_out  in  1  conditional branch taken, resolved in EX.
REQ-005 jal  in  1  JAL in ID;  jalr  in  1  JALR in ID.
REQ-006 id_rs1, id_rs2  in  5 each  ID source registers;  id_use_rs1, id_use_rs2  in  1 each  source actually read.
REQ-007 ex_rd  in  5  EX destination;  ex_mem_read  in  1  EX instruction is a load.
REQ-008 mem_req  in  1  MEM stage access pending;  mem_ack  in  1  data memory completes this cycle.
REQ-009 pc_src  out  3  000 PC+4, 001 branch, 010 JAL, 011 JALR.
REQ-010 pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register enables.
REQ-011 if_id_reset, id_ex_reset  out  1 each  synchronous flush to bubble.
REQ-012 mem_fault  out  1  one-cycle pulse on MEM timeout.

Function
REQ-013 SHALL implement FSM states RUN, MEM_WAIT, JALR_WAIT; outputs Mealy (zero-cycle latency from inputs).
REQ-014 Defaults every cycle: pc_src=000, all enables 1, flushes 0, mem_fault 0.
REQ-015 RUN priority: mem_req&!mem_ack > cond_hand_out > load-use > jal > jalr.
REQ-016 mem_req&!mem_ack: all four enables 0, no flush, pc_src=000; next MEM_WAIT, timeout counter cleared.
REQ-017 cond_hand_out: pc_src=001, if_id_reset=1, id_ex_reset=1; next RUN.
REQ-018 load-use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)): pc_en=0, if_id_en=0, id_ex_reset=1; next RUN.
REQ-019 jal: pc_src=010, if_id_reset=1; next RUN.
REQ-020 jalr: pc_en=0, if_id_en=0, id_ex_reset=1 (one bubble for target compute); next JALR_WAIT.
REQ-021 JALR_WAIT: pc_src=011, if_id_reset=1; next RUN; cond_hand_out, jal, jalr, load-use ignored (EX holds bubble).
REQ-022 JALR_WAIT with mem_req&!mem_ack: freeze as REQ-016, remain JALR_WAIT, redirect deferred until freeze lifts.
REQ-023 MEM_WAIT, mem_ack=0: freeze; 4-bit counter increments; branch/jump inputs ignored.
REQ-024 MEM_WAIT, mem_ack=1: behave exactly as RUN with mem term false this cycle; next state per RUN rules.
REQ-025 MEM_WAIT, counter==MEM_TIMEOUT-1 and mem_ack=0: mem_fault=1, treated as mem_ack=1 (REQ-024).
REQ-026 Counter saturates at 15; cleared on every entry to MEM_WAIT.

Reset
REQ-027 While rst_n=0: state RUN, counter 0, pc_src=000, all enables 0, if_id_reset=1, id_ex_reset=1, mem_fault=0.
REQ-028 Reset assertion mid-MEM_WAIT or mid-JALR_WAIT SHALL abandon the operation; first cycle after release is RUN.

Configuration
REQ-029 Macro HAZ_PERF_CNT_EN: when defined, add outputs stall_cnt[15:0] (cycles with pc_en=0) and flush_cnt[15:0] (cycles with if_id_reset=1, rst_n high), saturating at 16'hFFFF, reset 0.
REQ-030 When undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-031 Shared package SHALL hold pc_src encodings (PCSRC_SEQ/BR/JAL/JALR), FSM state typedef, 5-bit register-index type.
REQ-032 Load-use compare SHALL be sub-module hazard_detect (combinational); FSM and counters in top.

Verification
REQ-033 RUN, ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle pc_en=0, if_id_en=0, id_ex_reset=1; next cycle all defaults.
REQ-034 Same as 033 with ex_rd=0 -> no stall.
REQ-035 cond_hand_out=1 and jalr=1 same cycle -> pc_src=001, both flushes 1, next state RUN (no JALR_WAIT).
REQ-036 jalr=1 -> cycle0 pc_en=0, id_ex_reset=1; cycle1 pc_src=011, if_id_reset=1; cycle2 defaults.
REQ-037 mem_req=1, mem_ack=0 for 20 cycles, MEM_TIMEOUT=15 -> enables 0 for 15 cycles, mem_fault=1 on 15th, pipeline advances.
REQ-038 rst_n driven low during MEM_WAIT cycle 3 -> outputs per REQ-027 immediately; after release RUN, mem_fault never pulses.
